// File: rtl/seg7_time_display_ctrl_if.sv
// Avalon-MM write-only link between the 7-segment display controller and the segment PIO slave.
interface seg7_time_display_ctrl_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;

  modport master (output address, output write, output writedata, input waitrequest);
  modport slave  (input address, input write, input writedata, output waitrequest);
endinterface

// File: rtl/seg7_time_display_ctrl.sv
// mm:ss playback clock / "t"+track-number display, pushed to the 7-segment PIO over Avalon-MM
// whenever the shown pattern changes.
module seg7_time_display_ctrl #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          play,
  input  logic                          clr_time,
  input  logic                          track_valid,
  input  logic [7:0]                    track_num,
  seg7_time_display_ctrl_if.master      avm,
  output logic                          mode_track,
  output logic                          busy
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [6:0] SEG_T = 7'h07;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_WRITE} state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  presc_q, presc_d;
  logic [15:0]    time_q, time_d;      // {M10, M1, S10, S1} BCD
  logic [HW-1:0]  hold_q, hold_d;
  logic           mode_q, mode_d;
  logic [7:0]     track_q, track_d;
  logic           dirty_q, dirty_d;
  logic [19:0]    shift_q, shift_d;    // {hundreds, tens, units, binary}
  logic [2:0]     cnt_q, cnt_d;
  logic [31:0]    wdata_q, wdata_d;

  logic           tick, expire, set_dirty;
  logic [19:0]    conv_next;
  logic [27:0]    time_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  function automatic logic [15:0] time_inc(input logic [15:0] t);
    logic [3:0] s1, s10, m1, m10;
    {m10, m1, s10, s1} = t;
    if (s1 != 4'd9) s1 = s1 + 4'd1;
    else begin
      s1 = 4'd0;
      if (s10 != 4'd5) s10 = s10 + 4'd1;
      else begin
        s10 = 4'd0;
        if (m1 != 4'd9) m1 = m1 + 4'd1;
        else begin
          m1 = 4'd0;
          m10 = (m10 != 4'd9) ? m10 + 4'd1 : 4'd0;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  // One double-dabble step: correct each BCD nibble that would overflow on doubling, then shift.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (r[8+4*i +: 4] >= 4'd5) r[8+4*i +: 4] = r[8+4*i +: 4] + 4'd3;
    end
    return {r[18:0], 1'b0};
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_time_seg
    assign time_seg[gi*7 +: 7] = seg7(time_q[gi*4 +: 4]);
  end

  assign conv_next = dabble_step(shift_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      time_q  <= '0;
      hold_q  <= '0;
      mode_q  <= 1'b0;
      track_q <= '0;
      dirty_q <= 1'b1;
      shift_q <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      time_q  <= time_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      track_q <= track_d;
      dirty_q <= dirty_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    time_d    = time_q;
    hold_d    = hold_q;
    mode_d    = mode_q;
    track_d   = track_q;
    dirty_d   = dirty_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    tick      = 1'b0;
    expire    = 1'b0;

    if (clr_time) begin
      presc_d = '0;
      time_d  = '0;
    end else if (play) begin
      if (presc_q == TW'(TICK_CYCLES - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
        time_d  = time_inc(time_q);
      end else begin
        presc_d = presc_q + TW'(1);
      end
    end

    if (track_valid) begin
      track_d = track_num;
      mode_d  = 1'b1;
      hold_d  = HW'(HOLD_CYCLES - 1);
    end else if (mode_q) begin
      if (hold_q == '0) begin
        mode_d = 1'b0;
        expire = 1'b1;
      end else begin
        hold_d = hold_q - HW'(1);
      end
    end

    set_dirty = track_valid | expire | ((tick | clr_time) & ~mode_q);

    case (state_q)
      S_IDLE: begin
        if (dirty_q) begin
          dirty_d = 1'b0;
          if (mode_q) begin
            state_d = S_CONV;
            shift_d = {12'd0, track_q};
            cnt_d   = '0;
          end else begin
            state_d = S_WRITE;
            wdata_d = {4'd0, time_seg};
          end
        end
      end
      S_CONV: begin
        shift_d = conv_next;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_WRITE;
          wdata_d = {4'd0, SEG_T, seg7(conv_next[19:16]), seg7(conv_next[15:12]), seg7(conv_next[11:8])};
        end
      end
      S_WRITE: begin
        if (!avm.waitrequest) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An event in the same cycle the pending request is accepted must still cause a follow-up write.
    if (set_dirty) dirty_d = 1'b1;
  end

  assign avm.address   = 2'd0;
  assign avm.write     = (state_q == S_WRITE);
  assign avm.writedata = wdata_q;
  assign mode_track    = mode_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_seg7_time_display_ctrl.sv
// Scoreboard bench for seg7_time_display_ctrl: expected PIO patterns are queued as stimulus is driven
// and compared on every cycle the DUT holds avm.write high.
module tb_seg7_time_display_ctrl;

  logic       clk;
  logic       reset_n;
  logic       play;
  logic       clr_time;
  logic       track_valid;
  logic [7:0] track_num;
  logic       mode_track;
  logic       busy;

  seg7_time_display_ctrl_if avm ();

  seg7_time_display_ctrl #(.TICK_CYCLES(4), .HOLD_CYCLES(50)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .play        (play),
    .clr_time    (clr_time),
    .track_valid (track_valid),
    .track_num   (track_num),
    .avm         (avm.master),
    .mode_track  (mode_track),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          n_wr  = 0;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] segc(input int d);
    case (d)
      0: segc = 7'h40;  1: segc = 7'h79;  2: segc = 7'h24;  3: segc = 7'h30;
      4: segc = 7'h19;  5: segc = 7'h12;  6: segc = 7'h02;  7: segc = 7'h78;
      8: segc = 7'h00;  9: segc = 7'h10;  default: segc = 7'h7F;
    endcase
  endfunction

  function automatic logic [31:0] tpat(input int s);
    int m, sec;
    m   = s / 60;
    sec = s % 60;
    return {4'd0, segc(m / 10), segc(m % 10), segc(sec / 10), segc(sec % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every cycle a write is on the bus it must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset_n && avm.write) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("wdata", avm.writedata, sb[0]);
        if (!avm.waitrequest) begin
          void'(sb.pop_front());
          n_wr++;
          $display("write %0d data=%h", n_wr, avm.writedata);
        end
      end
    end
  end

  initial begin
    int n0, lat, hi;
    bit seen;

    reset_n = 1'b0; play = 1'b0; clr_time = 1'b0; track_valid = 1'b0; track_num = 8'd0;
    avm.waitrequest = 1'b0;

    // T1: reset values, then one 00:00 write after release
    step(3);
    chk("rst_write", 32'(avm.write), 32'd0);
    chk("rst_wdata", avm.writedata, 32'd0);
    chk("rst_addr", 32'(avm.address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mode", 32'(mode_track), 32'd0);
    sb.push_back(32'h0810_2040);
    reset_n = 1'b1;
    step(10);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    chk("t1_writes", 32'(n_wr), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);

    // T2: 60 ticks of playback, then pause
    n0 = n_wr;
    for (int k = 1; k <= 60; k++) sb.push_back(tpat(k));
    play = 1'b1;
    step(240);
    play = 1'b0;
    step(20);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    chk("t2_writes", 32'(n_wr - n0), 32'd60);
    chk("t2_last", avm.writedata, 32'h081E_6040);
    n0 = n_wr;
    step(30);
    chk("t2_paused", 32'(n_wr - n0), 32'd0);

    // T3: track 123 announcement, hold expiry, time write-back
    n0 = n_wr;
    sb.push_back(32'h00FE_5230);
    sb.push_back(tpat(60));
    track_num = 8'd123; track_valid = 1'b1;
    step(1);
    track_valid = 1'b0;
    lat = 0; seen = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      step(1);
      if (!seen && avm.write) begin seen = 1'b1; lat = j; end
      if (j == 1)  chk("t3_mode_set", 32'(mode_track), 32'd1);
      if (j == 3)  chk("t3_busy_conv", 32'(busy), 32'd1);
      if (j == 49) chk("t3_mode_hold", 32'(mode_track), 32'd1);
      if (j == 50) chk("t3_mode_off", 32'(mode_track), 32'd0);
    end
    chk("t3_latency", 32'(lat), 32'd9);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    chk("t3_writes", 32'(n_wr - n0), 32'd2);

    // T4: waitrequest stalls a write while the next tick arrives
    n0 = n_wr; hi = 0;
    sb.push_back(tpat(61));
    sb.push_back(tpat(62));
    avm.waitrequest = 1'b1;
    play = 1'b1;
    for (int p = 1; p <= 14; p++) begin
      step(1);
      if (avm.write) hi++;
      if (p == 8)  play = 1'b0;
      if (p == 10) avm.waitrequest = 1'b0;
    end
    chk("t4_write_cycles", 32'(hi), 32'd7);
    step(5);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    chk("t4_writes", 32'(n_wr - n0), 32'd2);

    // T5a: full run from 00:00 through 99:59 and wrap
    n0 = n_wr;
    for (int k = 0; k <= 6000; k++) sb.push_back(tpat(k % 6000));
    clr_time = 1'b1; play = 1'b1;
    step(1);
    clr_time = 1'b0;
    step(24000);
    play = 1'b0;
    step(5);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    chk("t5_writes", 32'(n_wr - n0), 32'd6001);
    chk("t5_wrap", avm.writedata, 32'h0810_2040);

    // T5b: clr_time coincides with the tick that would show 00:08
    n0 = n_wr;
    for (int k = 0; k <= 7; k++) sb.push_back(tpat(k));
    sb.push_back(tpat(0));
    clr_time = 1'b1; play = 1'b1;
    step(1);
    clr_time = 1'b0;
    step(31);
    clr_time = 1'b1;
    step(1);
    clr_time = 1'b0; play = 1'b0;
    step(5);
    chk("t5_clr_sb_empty", 32'(sb.size()), 32'd0);
    chk("t5_clr_writes", 32'(n_wr - n0), 32'd9);
    chk("t5_clr_wins", avm.writedata, 32'h0810_2040);

    // T6: asynchronous reset during a stalled write
    sb.push_back(tpat(0));
    avm.waitrequest = 1'b1;
    clr_time = 1'b1;
    step(1);
    clr_time = 1'b0;
    step(2);
    chk("t6_write_before", 32'(avm.write), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_write_async", 32'(avm.write), 32'd0);
    chk("t6_busy_async", 32'(busy), 32'd0);
    chk("t6_wdata_async", avm.writedata, 32'd0);
    sb.delete();
    step(2);
    n0 = n_wr;
    sb.push_back(32'h0810_2040);
    avm.waitrequest = 1'b0;
    reset_n = 1'b1;
    step(10);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
    chk("t6_writes", 32'(n_wr - n0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
